// File: rtl/mc_control_unit.sv
// mc_control_unit: registered instruction-decode control unit with a
// multiply interlock. One opcode is decoded per accepted cycle; HI/LO
// reads and a second mult are held off while a multiply is outstanding.
module mc_control_unit #(
    parameter int OP_W    = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  op_code,
    output logic             in_ready,
    output logic             out_valid,
    output logic             alu_b,
    output logic             mul,
    output logic [1:0]       source_wb,
    output logic             r_w,
    output logic             branch,
    output logic             illegal,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MC_W = $clog2(MUL_LAT + 1);

    // Registered state and its next-state values
    logic [MC_W-1:0]  mul_cnt_q,     mul_cnt_d;
    logic             out_valid_q,   out_valid_d;
    logic             alu_b_q,       alu_b_d;
    logic             mul_q,         mul_d;
    logic [1:0]       source_wb_q,   source_wb_d;
    logic             r_w_q,         r_w_d;
    logic             branch_q,      branch_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Decoded controls for the opcode currently presented
    logic [31:0]      op_ext_s;
    logic             dec_alu_b_s;
    logic             dec_mul_s;
    logic [1:0]       dec_source_wb_s;
    logic             dec_r_w_s;
    logic             dec_branch_s;
    logic             dec_illegal_s;
    logic             is_hilo_s;

    // Handshake signals
    logic             mul_busy_s;
    logic             stall_s;
    logic             ready_s;
    logic             accept_s;

    assign mul_busy_s = (mul_cnt_q != {MC_W{1'b0}});

    // Opcode class decode; opcodes above 15 are flagged illegal with no other control
    always_comb begin
        op_ext_s        = 32'(op_code);
        dec_alu_b_s     = 1'b0;
        dec_mul_s       = 1'b0;
        dec_source_wb_s = 2'd0;
        dec_r_w_s       = 1'b0;
        dec_branch_s    = 1'b0;
        dec_illegal_s   = 1'b0;
        if (op_ext_s > 32'd15) begin
            dec_illegal_s = 1'b1;
        end else begin
            case (op_ext_s[3:0])
                4'd0, 4'd1, 4'd3, 4'd4, 4'd5: begin
                    dec_r_w_s = 1'b1;
                end
                4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                    dec_alu_b_s = 1'b1;
                    dec_r_w_s   = 1'b1;
                end
                4'd11, 4'd12: begin
                    dec_branch_s = 1'b1;
                end
                4'd13: begin
                    dec_source_wb_s = 2'd1;
                    dec_r_w_s       = 1'b1;
                end
                4'd14: begin
                    dec_source_wb_s = 2'd2;
                    dec_r_w_s       = 1'b1;
                end
                4'd15: begin
                    dec_mul_s       = 1'b1;
                    dec_source_wb_s = 2'd2;
                end
                default: begin
                    dec_illegal_s = 1'b1;
                end
            endcase
        end
        // ghi, glo and mult all depend on the multiplier being idle
        is_hilo_s = !dec_illegal_s && (op_ext_s[3:0] >= 4'd13);
    end

    // Interlock, accept handshake and next-state computation
    always_comb begin
        stall_s  = in_valid && is_hilo_s && mul_busy_s;
        ready_s  = !rst && !stall_s;
        accept_s = in_valid && ready_s;

        if (accept_s && dec_mul_s) begin
            mul_cnt_d = MC_W'(MUL_LAT);
        end else if (mul_busy_s) begin
            mul_cnt_d = mul_cnt_q - MC_W'(1);
        end else begin
            mul_cnt_d = mul_cnt_q;
        end

        if (in_valid && !ready_s && !rst && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end

        // A cycle without accept becomes a bubble that never writes
        if (accept_s) begin
            out_valid_d = 1'b1;
            alu_b_d     = dec_alu_b_s;
            mul_d       = dec_mul_s;
            source_wb_d = dec_source_wb_s;
            r_w_d       = dec_r_w_s;
            branch_d    = dec_branch_s;
            illegal_d   = dec_illegal_s;
        end else begin
            out_valid_d = 1'b0;
            alu_b_d     = 1'b0;
            mul_d       = 1'b0;
            source_wb_d = 2'd0;
            r_w_d       = 1'b0;
            branch_d    = 1'b0;
            illegal_d   = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt_q     <= {MC_W{1'b0}};
            out_valid_q   <= 1'b0;
            alu_b_q       <= 1'b0;
            mul_q         <= 1'b0;
            source_wb_q   <= 2'd0;
            r_w_q         <= 1'b0;
            branch_q      <= 1'b0;
            illegal_q     <= 1'b0;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            mul_cnt_q     <= mul_cnt_d;
            out_valid_q   <= out_valid_d;
            alu_b_q       <= alu_b_d;
            mul_q         <= mul_d;
            source_wb_q   <= source_wb_d;
            r_w_q         <= r_w_d;
            branch_q      <= branch_d;
            illegal_q     <= illegal_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign in_ready    = ready_s;
    assign out_valid   = out_valid_q;
    assign alu_b       = alu_b_q;
    assign mul         = mul_q;
    assign source_wb   = source_wb_q;
    assign r_w         = r_w_q;
    assign branch      = branch_q;
    assign illegal     = illegal_q;
    assign mul_busy    = mul_busy_s;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_mc_control_unit;

    localparam int OP_W    = 5;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [OP_W-1:0]  op_code = '0;
    logic             in_ready;
    logic             out_valid;
    logic             alu_b;
    logic             mul;
    logic [1:0]       source_wb;
    logic             r_w;
    logic             branch;
    logic             illegal;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    // Model state: remaining busy cycles, stall counter, expected outputs
    int   m_busy  = 0;
    int   m_stall = 0;
    logic m_acc   = 1'b0;

    typedef struct packed {
        logic       vld;
        logic       alu_b;
        logic       mul;
        logic [1:0] src;
        logic       r_w;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    ctrl_t m_out = '0;

    mc_control_unit #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op_code(op_code),
        .in_ready(in_ready), .out_valid(out_valid), .alu_b(alu_b), .mul(mul),
        .source_wb(source_wb), .r_w(r_w), .branch(branch), .illegal(illegal),
        .mul_busy(mul_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Class table straight from the opcode definitions
    function automatic ctrl_t golden(input int op);
        ctrl_t c;
        c = '0;
        c.vld = 1'b1;
        if (op > 15)                                 c.illegal = 1'b1;
        else if (op inside {0, 1, 3, 4, 5})          c.r_w = 1'b1;
        else if (op inside {2, 6, 7, 8, 9, 10})      begin c.alu_b = 1'b1; c.r_w = 1'b1; end
        else if (op inside {11, 12})                 c.branch = 1'b1;
        else if (op == 13)                           begin c.src = 2'd1; c.r_w = 1'b1; end
        else if (op == 14)                           begin c.src = 2'd2; c.r_w = 1'b1; end
        else                                         begin c.mul = 1'b1; c.src = 2'd2; end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs
    task automatic cycle(input logic v, input int op, input logic r);
        logic exp_ready;
        rst      = r;
        in_valid = v;
        op_code  = OP_W'(op);
        @(negedge clk);
        exp_ready = !r && !(v && op >= 13 && op <= 15 && m_busy > 0);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        m_acc = v && exp_ready;
        if (r) begin
            m_busy  = 0;
            m_stall = 0;
            m_out   = '0;
        end else begin
            if (v && !exp_ready && m_stall < CNT_MAX) m_stall++;
            if (m_acc && op == 15)  m_busy = MUL_LAT;
            else if (m_busy > 0)    m_busy--;
            m_out = m_acc ? golden(op) : ctrl_t'(0);
        end
        @(posedge clk);
        #1;
        check("out_valid",   32'(out_valid),   32'(m_out.vld));
        check("alu_b",       32'(alu_b),       32'(m_out.alu_b));
        check("mul",         32'(mul),         32'(m_out.mul));
        check("source_wb",   32'(source_wb),   32'(m_out.src));
        check("r_w",         32'(r_w),         32'(m_out.r_w));
        check("branch",      32'(branch),      32'(m_out.branch));
        check("illegal",     32'(illegal),     32'(m_out.illegal));
        check("mul_busy",    32'(mul_busy),    32'(m_busy > 0));
        check("stall_count", 32'(stall_count), 32'(m_stall));
    endtask

    // Hold an opcode valid until the model accepts it, with a cycle budget
    task automatic present(input int op, output int waited);
        waited = 0;
        cycle(1'b1, op, 1'b0);
        while (!m_acc && waited < 3 * MUL_LAT) begin
            waited++;
            cycle(1'b1, op, 1'b0);
        end
        check("accept_budget", 32'(m_acc), 32'd1);
    endtask

    initial begin
        int w;
        @(posedge clk);
        #1;
        // Reset state
        cycle(1'b0, 0, 1'b1);
        cycle(1'b1, 13, 1'b1);

        // All 16 opcodes back-to-back; the 14 after 15 stalls
        for (int op = 0; op < 16; op++) begin
            present(op, w);
            check("no_stall_seq", 32'(w), 32'd0);
        end
        present(14, w);
        check("glo_after_mult_wait", 32'(w), 32'(MUL_LAT));
        cycle(1'b0, 0, 1'b0);

        // mult then ghi held valid: stalls MUL_LAT cycles
        cycle(1'b1, 0, 1'b1);
        present(15, w);
        present(13, w);
        check("ghi_wait", 32'(w), 32'(MUL_LAT));
        check("stall_cnt_after_ghi", 32'(stall_count), 32'(MUL_LAT));

        // mult, then R and I types while busy: no stall
        present(15, w);
        present(3, w);
        check("r_while_busy", 32'(w), 32'd0);
        present(6, w);
        check("i_while_busy", 32'(w), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0);

        // Illegal opcode while busy is never stalled
        present(15, w);
        present(20, w);
        check("illegal_no_stall", 32'(w), 32'd0);
        present(31, w);
        cycle(1'b0, 0, 1'b0);

        // Reset two cycles after mult, then glo accepted at once
        present(15, w);
        cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 14, 1'b1);
        present(14, w);
        check("glo_after_reset", 32'(w), 32'd0);

        // Back-to-back mults and ghi push stall_count into saturation
        for (int i = 0; i < 3; i++) begin
            present(15, w);
            present(15, w);
            check("mult_mult_wait", 32'(w), 32'(MUL_LAT));
            present(13, w);
        end
        check("stall_saturated", 32'(stall_count), 32'(CNT_MAX));

        // Random traffic biased toward interlocked opcodes
        cycle(1'b0, 0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            int  op;
            logic v, r;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 49) == 0);
            op = ($urandom_range(0, 1) == 1) ? $urandom_range(13, 15) : $urandom_range(0, 31);
            cycle(v, op, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
